bsg_cache_dma_rr_arbiter: RTL and testbench

Round-robin arbiter that shares one DMA channel between `num_cache_p` bsg_cache instances. It sits between the caches' DMA ports and a single downstream DMA consumer, such as a cache-to-AXI converter or a DRAM controller. A grant is held for one complete transaction: the packet plus a full block of fill or evict data. Grants then rotate fairly among requesters.

---
 rtl/bsg_cache_dma_rr_arbiter_if.sv | 44 ++++
 rtl/bsg_cache_dma_rr_arbiter.sv | 141 ++++++++++++++
 tb/tb_bsg_cache_dma_rr_arbiter.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/bsg_cache_dma_rr_arbiter_if.sv
// DMA bundle between N caches, the round-robin arbiter and one downstream DMA consumer.
// master = arbiter side, slave = environment (caches + memory).
interface bsg_cache_dma_rr_arbiter_if #(
  parameter int num_cache_p  = 4,
  parameter int addr_width_p = 28,
  parameter int data_width_p = 32
);
  localparam int dma_pkt_width_lp = addr_width_p + 1;
  localparam int lg_num_cache_lp  = $clog2(num_cache_p);

  logic [num_cache_p-1:0][dma_pkt_width_lp-1:0] dma_pkt_i;
  logic [num_cache_p-1:0]                       dma_pkt_v_i;
  logic [num_cache_p-1:0]                       dma_pkt_yumi_o;
  logic [num_cache_p-1:0][data_width_p-1:0]     dma_data_o;
  logic [num_cache_p-1:0]                       dma_data_v_o;
  logic [num_cache_p-1:0]                       dma_data_ready_i;
  logic [num_cache_p-1:0][data_width_p-1:0]     dma_data_i;
  logic [num_cache_p-1:0]                       dma_data_v_i;
  logic [num_cache_p-1:0]                       dma_data_yumi_o;
  logic [dma_pkt_width_lp-1:0]                  mem_pkt_o;
  logic                                         mem_pkt_v_o;
  logic                                         mem_pkt_yumi_i;
  logic [data_width_p-1:0]                      mem_data_i;
  logic                                         mem_data_v_i;
  logic                                         mem_data_ready_o;
  logic [data_width_p-1:0]                      mem_data_o;
  logic                                         mem_data_v_o;
  logic                                         mem_data_yumi_i;
  logic [lg_num_cache_lp-1:0]                   grant_id_o;

  modport master (
    input  dma_pkt_i, dma_pkt_v_i, dma_data_ready_i, dma_data_i, dma_data_v_i,
           mem_pkt_yumi_i, mem_data_i, mem_data_v_i, mem_data_yumi_i,
    output dma_pkt_yumi_o, dma_data_o, dma_data_v_o, dma_data_yumi_o,
           mem_pkt_o, mem_pkt_v_o, mem_data_ready_o, mem_data_o, mem_data_v_o, grant_id_o
  );

  modport slave (
    output dma_pkt_i, dma_pkt_v_i, dma_data_ready_i, dma_data_i, dma_data_v_i,
           mem_pkt_yumi_i, mem_data_i, mem_data_v_i, mem_data_yumi_i,
    input  dma_pkt_yumi_o, dma_data_o, dma_data_v_o, dma_data_yumi_o,
           mem_pkt_o, mem_pkt_v_o, mem_data_ready_o, mem_data_o, mem_data_v_o, grant_id_o
  );
endinterface

// File: rtl/bsg_cache_dma_rr_arbiter.sv
// Round-robin arbiter sharing one DMA channel among caches; a grant covers packet + full block.
// Optional per-cache read/write packet counters: define BSG_CACHE_DMA_ARB_STATS_EN.
module bsg_cache_dma_rr_arbiter #(
  parameter int num_cache_p           = 4,
  parameter int addr_width_p          = 28,
  parameter int data_width_p          = 32,
  parameter int block_size_in_words_p = 8
) (
  input  logic                          clk_i,
  input  logic                          reset_n_i,
  bsg_cache_dma_rr_arbiter_if.master    bus
`ifdef BSG_CACHE_DMA_ARB_STATS_EN
  ,
  output logic [num_cache_p-1:0][31:0]  rd_count_o,
  output logic [num_cache_p-1:0][31:0]  wr_count_o
`endif
);
  localparam int lg_num_cache_lp  = $clog2(num_cache_p);
  localparam int dma_pkt_width_lp = addr_width_p + 1;
  localparam int cnt_width_lp     = $clog2(block_size_in_words_p);

  typedef enum logic [1:0] {IDLE, PKT, FILL, EVICT} state_e;

  state_e                      r_state, w_state_next;
  logic [lg_num_cache_lp-1:0]  r_grant, r_rr_ptr, w_pick, w_rr_next;
  logic [lg_num_cache_lp:0]    w_sum;
  logic [cnt_width_lp-1:0]     r_cnt;
  logic                        w_found, w_beat, w_last;
  logic [dma_pkt_width_lp-1:0] w_pkt;
  logic [data_width_p-1:0]     w_evict_word;

  assign w_pkt        = bus.dma_pkt_i[r_grant];
  assign w_evict_word = bus.dma_data_i[r_grant];
  assign w_last       = (r_cnt == cnt_width_lp'(block_size_in_words_p - 1));
  assign w_beat       = ((r_state == FILL) && bus.mem_data_v_i && bus.dma_data_ready_i[r_grant])
                     || ((r_state == EVICT) && bus.mem_data_yumi_i);
  assign w_rr_next    = (r_grant == lg_num_cache_lp'(num_cache_p - 1))
                      ? '0 : r_grant + lg_num_cache_lp'(1);
  assign bus.grant_id_o = r_grant;

  // First requester at or after rr_ptr; scanning downward lets the nearest one win.
  always_comb begin
    // NOTE: every comb output gets a default before any branch so no latch is inferred.
    w_found = 1'b0;
    w_pick  = r_rr_ptr;
    w_sum   = '0;
    for (int i = num_cache_p - 1; i >= 0; i--) begin
      w_sum = {1'b0, r_rr_ptr} + (lg_num_cache_lp + 1)'(i);
      if (w_sum >= (lg_num_cache_lp + 1)'(num_cache_p))
        w_sum = w_sum - (lg_num_cache_lp + 1)'(num_cache_p);
      if (bus.dma_pkt_v_i[w_sum[lg_num_cache_lp-1:0]]) begin
        w_found = 1'b1;
        w_pick  = w_sum[lg_num_cache_lp-1:0];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) r_state <= IDLE;
    else            r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:        if (w_found) w_state_next = PKT;
      PKT:         if (bus.mem_pkt_yumi_i)
                     w_state_next = w_pkt[dma_pkt_width_lp-1] ? EVICT : FILL;
      FILL, EVICT: if (w_beat && w_last) w_state_next = IDLE;
      default:     w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_grant  <= '0;
      r_rr_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if ((r_state == IDLE) && w_found)          r_grant <= w_pick;
      if ((r_state == PKT) && bus.mem_pkt_yumi_i) r_cnt   <= '0;
      if (w_beat) begin
        r_cnt <= r_cnt + cnt_width_lp'(1);
        if (w_last) r_rr_ptr <= w_rr_next;
      end
    end
  end

  // Only the granted cache ever sees a valid/yumi; data outputs are zero outside their phase.
  always_comb begin
    bus.mem_pkt_v_o      = 1'b0;
    bus.mem_pkt_o        = '0;
    bus.dma_pkt_yumi_o   = '0;
    bus.mem_data_ready_o = 1'b0;
    bus.dma_data_v_o     = '0;
    bus.dma_data_o       = '0;
    bus.mem_data_o       = '0;
    bus.mem_data_v_o     = 1'b0;
    bus.dma_data_yumi_o  = '0;
    unique case (r_state)
      PKT: begin
        bus.mem_pkt_v_o             = 1'b1;
        bus.mem_pkt_o               = w_pkt;
        bus.dma_pkt_yumi_o[r_grant] = bus.mem_pkt_yumi_i;
      end
      FILL: begin
        bus.mem_data_ready_o      = bus.dma_data_ready_i[r_grant];
        bus.dma_data_v_o[r_grant] = bus.mem_data_v_i;
        bus.dma_data_o            = {num_cache_p{bus.mem_data_i}};
      end
      EVICT: begin
        bus.mem_data_o               = w_evict_word;
        bus.mem_data_v_o             = bus.dma_data_v_i[r_grant];
        bus.dma_data_yumi_o[r_grant] = bus.mem_data_yumi_i;
      end
      default: ;
    endcase
  end

`ifdef BSG_CACHE_DMA_ARB_STATS_EN
  logic [num_cache_p-1:0][31:0] r_rd_count, r_wr_count;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_rd_count <= '0;
      r_wr_count <= '0;
    end else if ((r_state == PKT) && bus.mem_pkt_yumi_i) begin
      for (int c = 0; c < num_cache_p; c++) begin
        if (r_grant == lg_num_cache_lp'(c)) begin
          if (w_pkt[dma_pkt_width_lp-1]) r_wr_count[c] <= r_wr_count[c] + 32'd1;
          else                           r_rd_count[c] <= r_rd_count[c] + 32'd1;
        end
      end
    end
  end

  assign rd_count_o = r_rd_count;
  assign wr_count_o = r_wr_count;
`endif
endmodule

// File: tb/tb_bsg_cache_dma_rr_arbiter.sv
// Self-checking bench: directed + randomized transactions against a transaction-level model
// (round-robin pointer, per-transaction word lists, per-cache packet counts).
module tb_bsg_cache_dma_rr_arbiter;
  localparam int N  = 4;
  localparam int AW = 28;
  localparam int DW = 32;
  localparam int B  = 8;
  localparam int PW = AW + 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bsg_cache_dma_rr_arbiter_if #(.num_cache_p(N), .addr_width_p(AW), .data_width_p(DW)) bus ();

`ifdef BSG_CACHE_DMA_ARB_STATS_EN
  logic [N-1:0][31:0] rd_count, wr_count;
`endif

  bsg_cache_dma_rr_arbiter #(
    .num_cache_p(N), .addr_width_p(AW), .data_width_p(DW), .block_size_in_words_p(B)
  ) dut (
    .clk_i     (clk),
    .reset_n_i (rst_n),
    .bus       (bus)
`ifdef BSG_CACHE_DMA_ARB_STATS_EN
    ,
    .rd_count_o(rd_count),
    .wr_count_o(wr_count)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;
  int rr_model = 0;
  int exp_rd[N];
  int exp_wr[N];

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic idle_inputs();
    bus.dma_pkt_i        = '0;
    bus.dma_pkt_v_i      = '0;
    bus.dma_data_ready_i = '0;
    bus.dma_data_i       = '0;
    bus.dma_data_v_i     = '0;
    bus.mem_pkt_yumi_i   = 1'b0;
    bus.mem_data_i       = '0;
    bus.mem_data_v_i     = 1'b0;
    bus.mem_data_yumi_i  = 1'b0;
  endtask

  task automatic model_reset();
    rr_model = 0;
    for (int c = 0; c < N; c++) begin
      exp_rd[c] = 0;
      exp_wr[c] = 0;
    end
  endtask

  task automatic check_all_quiet(input string tag);
    check({tag, "_pkt_v"},     64'(bus.mem_pkt_v_o), 64'd0);
    check({tag, "_pkt"},       64'(bus.mem_pkt_o), 64'd0);
    check({tag, "_pkt_yumi"},  64'(bus.dma_pkt_yumi_o), 64'd0);
    check({tag, "_mem_ready"}, 64'(bus.mem_data_ready_o), 64'd0);
    check({tag, "_dma_v"},     64'(bus.dma_data_v_o), 64'd0);
    check({tag, "_dma_yumi"},  64'(bus.dma_data_yumi_o), 64'd0);
    check({tag, "_mem_v"},     64'(bus.mem_data_v_o), 64'd0);
    check({tag, "_mem_data"},  64'(bus.mem_data_o), 64'd0);
    for (int c = 0; c < N; c++) check({tag, "_dma_data"}, 64'(bus.dma_data_o[c]), 64'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b0;
    #1;
    check_all_quiet("reset");
    check("reset_grant", 64'(bus.grant_id_o), 64'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // mode: 0 random stalls, 1 no stalls, 2 handshake on alternate cycles.
  // hold_at: word index that sees ready low for 5 cycles; abort_after: return after that many words.
  task automatic run_txn(input logic [N-1:0] req, input logic [N-1:0] wr, input bit rand_addr,
                         input logic [AW-1:0] addr, input bit seq_words, input int mode,
                         input int hold_at, input int abort_after);
    logic [N-1:0][PW-1:0] pkts;
    logic [DW-1:0]        words [B];
    logic [N-1:0]         oh;
    int                   g, w, k, hold_left, stalls, yumi_cnt;
    bit                   go, v, yum, is_wr;

    g = -1;
    for (int i = 0; i < N; i++)
      if (g < 0 && req[(rr_model + i) % N]) g = (rr_model + i) % N;
    for (int c = 0; c < N; c++)
      pkts[c] = {wr[c], rand_addr ? AW'($urandom) : addr};
    is_wr = wr[g];
    oh    = N'(1) << g;
    for (int i = 0; i < B; i++)
      words[i] = seq_words ? (is_wr ? DW'(32'hA0 + i) : DW'(i)) : DW'($urandom);

    @(negedge clk);
    bus.dma_pkt_i   = pkts;
    bus.dma_pkt_v_i = req;
    #1;
    check("idle_pkt_v", 64'(bus.mem_pkt_v_o), 64'd0);

    stalls = (mode == 0) ? int'($urandom_range(0, 2)) : 0;
    for (int s = 0; s <= stalls; s++) begin
      @(negedge clk);
      bus.mem_pkt_yumi_i = (s == stalls);
      #1;
      check("pkt_v", 64'(bus.mem_pkt_v_o), 64'd1);
      check("pkt", 64'(bus.mem_pkt_o), 64'(pkts[g]));
      check("grant", 64'(bus.grant_id_o), 64'(g));
      check("pkt_yumi", 64'(bus.dma_pkt_yumi_o), (s == stalls) ? 64'(oh) : 64'd0);
    end
    if (is_wr) exp_wr[g]++; else exp_rd[g]++;

    w = 0; k = 0; hold_left = 5; yumi_cnt = 0;
    while (w < B && k < 400 && w != abort_after) begin
      @(negedge clk);
      bus.mem_pkt_yumi_i = 1'b0;
      bus.dma_pkt_v_i[g] = 1'b0;
      go = (mode == 0) ? ($urandom_range(0, 3) != 0) : (mode == 2) ? (k % 2 == 1) : 1'b1;
      v  = (mode == 0) ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (w == hold_at && hold_left > 0) begin
        go = 1'b0;
        hold_left--;
      end
      for (int c = 0; c < N; c++) bus.dma_data_i[c] = DW'($urandom);
      bus.dma_data_ready_i = N'($urandom);
      bus.dma_data_v_i     = N'($urandom);
      if (!is_wr) begin
        bus.mem_data_v_i        = v;
        bus.mem_data_i          = v ? words[w] : DW'($urandom);
        bus.dma_data_ready_i[g] = go;
        bus.mem_data_yumi_i     = 1'b0;
        #1;
        check("fill_ready", 64'(bus.mem_data_ready_o), 64'(go));
        check("fill_v", 64'(bus.dma_data_v_o), v ? 64'(oh) : 64'd0);
        check("fill_no_evict_v", 64'(bus.mem_data_v_o), 64'd0);
        check("fill_no_yumi", 64'(bus.dma_data_yumi_o), 64'd0);
        if (v && go) begin
          for (int c = 0; c < N; c++) check("fill_data", 64'(bus.dma_data_o[c]), 64'(words[w]));
          w++;
        end
      end else begin
        bus.dma_data_v_i[g] = v;
        bus.dma_data_i[g]   = words[w];
        yum                 = go && v;
        bus.mem_data_yumi_i = yum;
        bus.mem_data_v_i    = 1'($urandom);
        bus.mem_data_i      = DW'($urandom);
        #1;
        check("evict_v", 64'(bus.mem_data_v_o), 64'(v));
        if (v) check("evict_data", 64'(bus.mem_data_o), 64'(words[w]));
        check("evict_yumi", 64'(bus.dma_data_yumi_o), yum ? 64'(oh) : 64'd0);
        check("evict_ready", 64'(bus.mem_data_ready_o), 64'd0);
        check("evict_no_fill_v", 64'(bus.dma_data_v_o), 64'd0);
        if (yum) begin
          w++;
          yumi_cnt++;
        end
      end
      check("data_pkt_yumi", 64'(bus.dma_pkt_yumi_o), 64'd0);
      k++;
    end
    if (w == abort_after) return;

    check("data_done", 64'(w), 64'(B));
    if (is_wr) check("evict_yumi_pulses", 64'(yumi_cnt), 64'(B));
    rr_model = (g + 1) % N;

    @(negedge clk);
    idle_inputs();
    #1;
    check("done_pkt_v", 64'(bus.mem_pkt_v_o), 64'd0);
    check("done_dma_v", 64'(bus.dma_data_v_o), 64'd0);
    check("done_ready", 64'(bus.mem_data_ready_o), 64'd0);
    check("done_grant", 64'(bus.grant_id_o), 64'(g));
  endtask

  initial begin
    idle_inputs();
    model_reset();
    #1;
    check_all_quiet("por");
    check("por_grant", 64'(bus.grant_id_o), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Single read from cache 2, then single evict from cache 0 with alternating yumi.
    run_txn(4'b0100, 4'b0000, 1'b0, AW'(28'h100), 1'b1, 1, -1, -1);
    run_txn(4'b0001, 4'b0001, 1'b0, AW'(28'h200), 1'b1, 2, -1, -1);

    // Fairness from reset with every cache requesting.
    do_reset();
    for (int t = 0; t < 6; t++)
      run_txn(4'b1111, N'($urandom), 1'b1, '0, 1'b0, 0, -1, -1);

    // Downstream ready held low for 5 cycles mid-burst.
    run_txn(4'b0010, 4'b0000, 1'b1, '0, 1'b0, 1, 3, -1);

    for (int t = 0; t < 20; t++)
      run_txn(N'($urandom_range(1, 15)), N'($urandom), 1'b1, '0, 1'b0, 0, -1, -1);

    // Reset during a fill after four words, then a fresh grant to cache 3.
    run_txn(4'b0010, 4'b0000, 1'b1, '0, 1'b1, 1, -1, 4);
    @(negedge clk);
    bus.mem_data_v_i     = 1'b1;
    bus.dma_data_ready_i = 4'b0010;
    #1;
    check("pre_abort_fill_v", 64'(bus.dma_data_v_o), 64'b0010);
    rst_n = 1'b0;
    #1;
    check_all_quiet("abort");
    check("abort_grant", 64'(bus.grant_id_o), 64'd0);
    model_reset();
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    run_txn(4'b1000, 4'b0000, 1'b1, '0, 1'b0, 0, -1, -1);

    // Cache 1: three reads and two writes.
    for (int t = 0; t < 5; t++)
      run_txn(4'b0010, (t < 3) ? 4'b0000 : 4'b0010, 1'b1, '0, 1'b0, 0, -1, -1);

`ifdef BSG_CACHE_DMA_ARB_STATS_EN
    for (int c = 0; c < N; c++) begin
      check("rd_count", 64'(rd_count[c]), 64'(exp_rd[c]));
      check("wr_count", 64'(wr_count[c]), 64'(exp_wr[c]));
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
